// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: holds downstream logic in reset until PLL lock has been stable,
// re-asserts reset on lock loss or soft reset, and counts lock losses.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOSS_W        = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              pll_lock_i,
  input  logic              soft_reset_i,
  output logic              rst_out_o,
  output logic              ready_o,
  output logic              lock_lost_o,
  output logic [LOSS_W-1:0] loss_count_o
);
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  typedef enum logic [1:0] {HOLD, STABLE, RUN} state_t;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_q;
  logic                   ready_q;
  logic                   lost_q;
  logic [LOSS_W-1:0]      loss_q;
  logic                   lock_s;
  assign lock_s       = sync_q[SYNC_STAGES-1];
  assign rst_out_o    = rst_q;
  assign ready_o      = ready_q;
  assign lock_lost_o  = lost_q;
  assign loss_count_o = loss_q;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q  <= '0;
      state_q <= HOLD;
      cnt_q   <= '0;
      rst_q   <= 1'b1;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
      loss_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock_i};
      lost_q <= 1'b0;
      case (state_q)
        HOLD: begin
          if (lock_s) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end
        end
        STABLE: begin
          if (!lock_s || soft_reset_i) begin
            state_q <= HOLD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= RUN;
            rst_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          // a lock loss takes priority over a simultaneous soft reset so it is still counted
          if (!lock_s || soft_reset_i) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            rst_q   <= 1'b1;
            ready_q <= 1'b0;
            lost_q  <= !lock_s;
            loss_q  <= (!lock_s && loss_q != '1) ? loss_q + 1'b1 : loss_q;
          end else begin
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= HOLD;
          cnt_q   <= '0;
          rst_q   <= 1'b1;
          ready_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed and random checks of the PLL reset sequencer against
// a run-length model of lock stability.
module tb_pll_reset_sequencer;
  localparam int SS = 2;
  localparam int SC = 8;
  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       soft_reset;
  logic       rst_out;
  logic       ready;
  logic       lock_lost;
  logic [7:0] loss_count;
  logic       rst_out2;
  logic       ready2;
  logic       lock_lost2;
  logic [1:0] loss_count2;
  int vectors = 0;
  int miscompares = 0;

  pll_reset_sequencer #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .LOSS_W(8)) dut (
    .clock_i(clk), .reset_i(rst), .pll_lock_i(pll_lock), .soft_reset_i(soft_reset),
    .rst_out_o(rst_out), .ready_o(ready), .lock_lost_o(lock_lost), .loss_count_o(loss_count));

  pll_reset_sequencer #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .LOSS_W(2)) dut2 (
    .clock_i(clk), .reset_i(rst), .pll_lock_i(pll_lock), .soft_reset_i(soft_reset),
    .rst_out_o(rst_out2), .ready_o(ready2), .lock_lost_o(lock_lost2), .loss_count_o(loss_count2));

  always #5 clk = ~clk;

  // Model: m_run counts consecutive synchronized-lock cycles since the last restart;
  // reset is released once it exceeds SC, ready follows one cycle later.
  logic [SS-1:0] m_hist;
  int            m_run;
  int            m_losses;
  logic          m_pulse;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hist   <= '0;
      m_run    <= 0;
      m_losses <= 0;
      m_pulse  <= 1'b0;
    end else begin
      m_hist  <= {m_hist[SS-2:0], pll_lock};
      m_pulse <= !m_hist[SS-1] && m_run >= SC + 1;
      if (!m_hist[SS-1]) begin
        if (m_run >= SC + 1) m_losses <= m_losses + 1;
        m_run <= 0;
      end else if (soft_reset && m_run > 0) begin
        m_run <= 0;
      end else begin
        m_run <= (m_run < SC + 2) ? m_run + 1 : m_run;
      end
    end
  end

  function automatic logic [13:0] dut_v();
    return {rst_out, ready, lock_lost, loss_count, loss_count2, rst_out2 ^ rst_out};
  endfunction

  function automatic logic [13:0] mdl_v();
    logic [7:0] c8;
    logic [1:0] c2;
    c8 = 8'((m_losses > 255) ? 255 : m_losses);
    c2 = 2'((m_losses > 3) ? 3 : m_losses);
    return {m_run < SC + 1, m_run >= SC + 2, m_pulse, c8, c2, 1'b0};
  endfunction

  task automatic tick(input logic lk, input logic sr);
    pll_lock   = lk;
    soft_reset = sr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    pll_lock   = 1'b0;
    soft_reset = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_release(output int n);
    n = 0;
    do begin
      tick(1'b1, 1'b0);
      n++;
    end while (rst_out !== 1'b0 && n < 40);
  endtask

  task automatic test_reset();
    do_reset();
    if (dut_v() !== 14'b1_0_0_00000000_00_0) begin
      miscompares++;
      $display("FAIL reset_state: got %h exp %h", dut_v(), 14'b1_0_0_00000000_00_0);
    end
    vectors++;
    if (dut_v() !== mdl_v()) begin
      miscompares++;
      $display("FAIL reset_model: got %h exp %h", dut_v(), mdl_v());
    end
    vectors++;
  endtask

  task automatic test_release();
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1, 1'b0);
      if ({rst_out, ready} !== {i <= 10, i >= 12}) begin
        miscompares++;
        $display("FAIL release edge %0d: got rst=%b rdy=%b exp rst=%b rdy=%b", i, rst_out, ready, i <= 10, i >= 12);
      end
      vectors++;
      if (dut_v() !== mdl_v()) begin
        miscompares++;
        $display("FAIL release_model edge %0d: got %h exp %h", i, dut_v(), mdl_v());
      end
      vectors++;
    end
    if (loss_count !== 8'd0) begin
      miscompares++;
      $display("FAIL release_loss_count: got %0d exp 0", loss_count);
    end
    vectors++;
  endtask

  task automatic test_glitch();
    int n;
    do_reset();
    repeat (7) tick(1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b0);
    if (rst_out !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_hold: got rst=%b exp 1", rst_out);
    end
    vectors++;
    wait_release(n);
    if (n != 11) begin
      miscompares++;
      $display("FAIL glitch_latency: got %0d edges exp 11", n);
    end
    vectors++;
    if (loss_count !== 8'd0 || dut_v() !== mdl_v()) begin
      miscompares++;
      $display("FAIL glitch_model: got %h exp %h", dut_v(), mdl_v());
    end
    vectors++;
  endtask

  task automatic test_loss();
    int n;
    repeat (2) tick(1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick(1'b0, 1'b0);
      if ({rst_out, ready, lock_lost} !== {i >= 3, i < 3, i == 3}) begin
        miscompares++;
        $display("FAIL loss edge %0d: got %b exp %b", i, {rst_out, ready, lock_lost}, {i >= 3, i < 3, i == 3});
      end
      vectors++;
    end
    if (loss_count !== 8'd1 || loss_count2 !== 2'd1) begin
      miscompares++;
      $display("FAIL loss_count: got %0d/%0d exp 1/1", loss_count, loss_count2);
    end
    vectors++;
    wait_release(n);
    if (n != 11 || dut_v() !== mdl_v()) begin
      miscompares++;
      $display("FAIL loss_relock: got %0d edges %h exp 11 edges %h", n, dut_v(), mdl_v());
    end
    vectors++;
  endtask

  task automatic test_saturation();
    int n;
    int pulses = 0;
    do_reset();
    wait_release(n);
    for (int k = 1; k <= 5; k++) begin
      tick(1'b1, 1'b0);
      repeat (4) begin
        tick(1'b0, 1'b0);
        if (lock_lost2 === 1'b1) pulses++;
      end
      if (loss_count2 !== 2'((k > 3) ? 3 : k) || loss_count !== 8'(k)) begin
        miscompares++;
        $display("FAIL saturation loss %0d: got %0d/%0d exp %0d/%0d", k, loss_count2, loss_count, (k > 3) ? 3 : k, k);
      end
      vectors++;
      if (dut_v() !== mdl_v()) begin
        miscompares++;
        $display("FAIL saturation_model loss %0d: got %h exp %h", k, dut_v(), mdl_v());
      end
      vectors++;
      wait_release(n);
    end
    if (pulses != 5) begin
      miscompares++;
      $display("FAIL saturation_pulses: got %0d exp 5", pulses);
    end
    vectors++;
  endtask

  task automatic test_soft_reset();
    int n;
    do_reset();
    wait_release(n);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    if ({rst_out, ready, lock_lost} !== 3'b100) begin
      miscompares++;
      $display("FAIL soft_assert: got %b exp 100", {rst_out, ready, lock_lost});
    end
    vectors++;
    n = 1;
    while (rst_out === 1'b1 && n < 40) begin
      tick(1'b1, 1'b0);
      if (rst_out === 1'b1) n++;
    end
    if (n != 9 || loss_count !== 8'd0) begin
      miscompares++;
      $display("FAIL soft_hold: got %0d cycles cnt %0d exp 9 cycles cnt 0", n, loss_count);
    end
    vectors++;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    if ({lock_lost, loss_count} !== {1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL soft_with_loss: got lost=%b cnt=%0d exp lost=1 cnt=1", lock_lost, loss_count);
    end
    vectors++;
    tick(1'b0, 1'b0);
    if (dut_v() !== mdl_v()) begin
      miscompares++;
      $display("FAIL soft_model: got %h exp %h", dut_v(), mdl_v());
    end
    vectors++;
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    wait_release(n);
    repeat (3) tick(1'b0, 1'b0);
    wait_release(n);
    tick(1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    if ({rst_out, ready, loss_count} !== {1'b1, 1'b0, 8'd0} || dut_v() !== mdl_v()) begin
      miscompares++;
      $display("FAIL async_reset: got %h exp %h", dut_v(), mdl_v());
    end
    vectors++;
    @(negedge clk);
    rst = 1'b0;
    wait_release(n);
    if (n != 11) begin
      miscompares++;
      $display("FAIL async_release: got %0d edges exp 11", n);
    end
    vectors++;
  endtask

  task automatic test_random();
    logic lk = 1'b1;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) lk = ~lk;
      tick(lk, $urandom_range(0, 39) == 0);
      if (dut_v() !== mdl_v()) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %h exp %h", i, dut_v(), mdl_v());
      end
      vectors++;
    end
  endtask

  initial begin
    rst        = 1'b1;
    pll_lock   = 1'b0;
    soft_reset = 1'b0;
    test_reset();
    test_release();
    test_glitch();
    test_loss();
    test_saturation();
    test_soft_reset();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
